// File: rtl/clk_en_gen_pkg.sv
// Shared constants and types for the multi-channel clock-enable generator.
// Holds the CTRL register bit map and the default divide ratio used at top level.
package clk_en_gen_pkg;

  localparam int unsigned CTRL_BIT_STEP = 31;
  localparam int unsigned CLK_DEF_DIV   = 24;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_HOLD,
    CH_BYPASS,
    CH_COUNT
  } chan_mode_e;

endpackage

// File: rtl/clk_en_chan.sv
// One divide channel: counter, shadowed ratio and terminal-count logic.
// Emits a registered 1-cycle enable pulse (ce) and a toggle (tick) of period 2*D.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned CW      = 24,
  parameter int unsigned DEF_DIV = CLK_DEF_DIV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] div,
  input  logic          div_wr,
  input  logic          hold,
  input  logic          step_pulse,
  output logic          ce,
  output logic          tick
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] shadow;
  logic          pend;
  logic          tc;
  logic          load;
  chan_mode_e    mode;

  always_comb begin
    mode = CH_OFF;
    if (en) begin
      if (hold)                     mode = CH_HOLD;
      else if (shadow <= CW'(1))    mode = CH_BYPASS;
      else                          mode = CH_COUNT;
    end
  end

  // pend remembers a DIV write until the next period boundary, so shadow
  // only ever changes at a terminal count (or at once while disabled).
  always_comb begin
    tc   = (mode == CH_BYPASS) ||
           ((mode == CH_COUNT) && (cnt == shadow - CW'(1)));
    load = (pend || div_wr) && ((mode == CH_OFF) || tc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      shadow <= CW'(DEF_DIV);
      pend   <= 1'b0;
      ce     <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (load) shadow <= div;
      pend <= (pend || div_wr) && !load;
      case (mode)
        CH_OFF: begin
          cnt  <= '0;
          ce   <= 1'b0;
          tick <= 1'b0;
        end
        CH_HOLD: begin
          ce   <= step_pulse;
          tick <= tick ^ step_pulse;
        end
        CH_BYPASS: begin
          cnt  <= '0;
          ce   <= 1'b1;
          tick <= ~tick;
        end
        default: begin
          cnt  <= tc ? '0 : cnt + CW'(1);
          ce   <= tc;
          tick <= tick ^ tc;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: bus register file, read mux and NCH divide channels.
// Optional single-step of channel 0 is built when CLKGEN_STEP_EN is defined.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 24,
  parameter int unsigned DEF_DIV = CLK_DEF_DIV,
  parameter int unsigned AW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bus_w,
  input  logic [AW-1:0]  bus_addr,
  input  logic [31:0]    bus_wdata,
  output logic [31:0]    bus_rdata,
  input  logic           step_req,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] tick
);

  logic [CW-1:0]  div_q [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] en_nxt;
  logic [NCH-1:0] div_wr;
  logic           wr_ctrl;
  logic           hold0;
  logic           step_pulse0;
  logic           step_rd;
  logic [31:0]    rd_nxt;
  logic           unused_wdata;

  assign unused_wdata = ^bus_wdata;

  // Channels see the post-write enable so a CTRL write acts on the same edge.
  always_comb begin
    wr_ctrl = bus_w && (bus_addr == AW'(NCH));
    for (int unsigned i = 0; i < NCH; i++) begin
      div_wr[i] = bus_w && (bus_addr == AW'(i));
    end
    en_nxt = wr_ctrl ? bus_wdata[NCH-1:0] : en_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) div_q[i] <= CW'(DEF_DIV);
      en_q <= '1;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (div_wr[i]) div_q[i] <= bus_wdata[CW-1:0];
      end
      en_q <= en_nxt;
    end
  end

`ifdef CLKGEN_STEP_EN
  logic step_q;
  logic step_nxt;
  logic step_d;

  assign step_nxt    = wr_ctrl ? bus_wdata[CTRL_BIT_STEP] : step_q;
  assign hold0       = en_nxt[0] && step_nxt;
  assign step_pulse0 = hold0 && step_req && !step_d;
  assign step_rd     = step_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
      step_d <= 1'b0;
    end else begin
      step_q <= step_nxt;
      step_d <= step_req;
    end
  end
`else
  logic unused_step;

  assign unused_step = step_req;
  assign hold0       = 1'b0;
  assign step_pulse0 = 1'b0;
  assign step_rd     = 1'b0;
`endif

  always_comb begin
    rd_nxt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus_addr == AW'(i)) rd_nxt = 32'(div_q[i]);
    end
    if (bus_addr == AW'(NCH)) begin
      rd_nxt[NCH-1:0]       = en_q;
      rd_nxt[CTRL_BIT_STEP] = step_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus_rdata <= '0;
    else      bus_rdata <= rd_nxt;
  end

  logic [NCH-1:0] hold_v;
  logic [NCH-1:0] step_v;

  assign hold_v = NCH'(hold0);
  assign step_v = NCH'(step_pulse0);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [CW-1:0] div_in;

    // A write on the terminal-count edge must win, so feed the incoming value.
    assign div_in = div_wr[g] ? bus_wdata[CW-1:0] : div_q[g];

    clk_en_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en_nxt[g]),
      .div        (div_in),
      .div_wr     (div_wr[g]),
      .hold       (hold_v[g]),
      .step_pulse (step_v[g]),
      .ce         (ce[g]),
      .tick       (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: cycle model feeds a scoreboard of expected ce/tick/rdata.
// Step scenarios are exercised when CLKGEN_STEP_EN is defined.
module tb_clk_en_gen;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 24;
  localparam int unsigned AW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           bus_w;
  logic [AW-1:0]  bus_addr;
  logic [31:0]    bus_wdata;
  logic [31:0]    bus_rdata;
  logic           step_req;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] tick;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          cyc         = 0;

  typedef struct packed {
    logic [3:0]  ce;
    logic [3:0]  tick;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  logic [23:0] m_div [4];
  logic [23:0] m_sh  [4];
  logic [23:0] m_cnt [4];
  logic [3:0]  m_ce, m_tick, m_en;
  logic        m_step, m_sq;

  clk_en_gen #(.NCH(NCH), .CW(CW), .DEF_DIV(24), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_w     (bus_w),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .step_req  (step_req),
    .ce        (ce),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int unsigned c = 0; c < 4; c++) begin
      m_div[c] = 24'd24;
      m_sh[c]  = 24'd24;
      m_cnt[c] = '0;
    end
    m_ce = '0; m_tick = '0; m_en = 4'hF; m_step = 1'b0; m_sq = 1'b0;
    sb.delete();
    cyc = 0;
  endtask

  // Reference behaviour for one rising edge; pushes the outputs it predicts.
  task automatic model_edge();
    logic [23:0] nd [4];
    logic [3:0]  ne;
    logic        ns, pulse;
    logic [23:0] d;
    exp_t        x;
    x.rdata = '0;
    if (bus_addr < 4)       x.rdata = {8'h00, m_div[bus_addr[1:0]]};
    else if (bus_addr == 4) x.rdata = {m_step, 27'd0, m_en};
    nd = m_div; ne = m_en; ns = m_step;
    if (bus_w) begin
      if (bus_addr < 4) nd[bus_addr[1:0]] = bus_wdata[23:0];
      else if (bus_addr == 4) begin
        ne = bus_wdata[3:0];
`ifdef CLKGEN_STEP_EN
        ns = bus_wdata[31];
`endif
      end
    end
    pulse = step_req & ~m_sq;
    for (int unsigned c = 0; c < 4; c++) begin
      d = m_sh[c];
      if (!ne[c]) begin
        m_cnt[c] = '0; m_ce[c] = 1'b0; m_tick[c] = 1'b0; m_sh[c] = nd[c];
      end else if (c == 0 && ns) begin
        m_ce[0] = pulse; m_tick[0] = m_tick[0] ^ pulse;
      end else if (d <= 1 || m_cnt[c] == d - 1) begin
        m_cnt[c] = '0; m_ce[c] = 1'b1; m_tick[c] = ~m_tick[c]; m_sh[c] = nd[c];
      end else begin
        m_cnt[c] = m_cnt[c] + 1; m_ce[c] = 1'b0;
      end
    end
    m_sq = step_req; m_div = nd; m_en = ne; m_step = ns;
    x.ce = m_ce; x.tick = m_tick;
    sb.push_back(x);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; bus_w = 1'b0; bus_addr = '0; bus_wdata = '0; step_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    int first = 0, second = 0;
    logic t24 = 1'b0;
    rst = 1'b0; bus_w = 1'b0; bus_addr = '0; bus_wdata = '0; step_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ce, tick, bus_rdata} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_state got ce=%h tick=%h rdata=%h want all 0", ce, tick, bus_rdata);
    end
    rst = 1'b1;
    model_reset();
    repeat (50) begin
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL reset_run cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
      if (cyc == 1) begin
        vectors++;
        if (bus_rdata !== 32'd24) begin
          miscompares++;
          $display("FAIL reset_div0 got %h want 00000018", bus_rdata);
        end
        bus_addr = 4'd4;
      end
      if (cyc == 2) begin
        vectors++;
        if (bus_rdata !== 32'h0000000F) begin
          miscompares++;
          $display("FAIL reset_ctrl got %h want 0000000f", bus_rdata);
        end
      end
      if (cyc == 24) t24 = tick[0];
      if (ce[0] && first == 0) first = cyc;
      else if (ce[0] && second == 0) second = cyc;
    end
    vectors++;
    if (first != 24 || second != 48 || t24 !== 1'b1 || tick[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ce0_timing got first=%0d second=%0d tick24=%b tick50=%b want 24 48 1 0",
               first, second, t24, tick[0]);
    end
  endtask

  // Scenario driver: write (addr,data) after sampling cycle wcyc, log ce[chan] cycles.
  task automatic run_write_scenario(input string name, input int wcyc, input logic [3:0] waddr,
                                    input logic [31:0] wdata, input int chan, input int ncyc,
                                    input int exp0, input int period);
    exp_t e;
    int hits[$];
    do_reset();
    bus_addr = waddr;
    for (int n = 0; n < ncyc; n++) begin
      bus_w = (cyc == wcyc);
      bus_wdata = wdata;
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 name, cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
      if (ce[chan]) hits.push_back(cyc);
    end
    bus_w = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (hits.size() <= k || hits[k] != exp0 + k * period) begin
        miscompares++;
        $display("FAIL %s_pulse%0d got %0d want %0d", name, k,
                 (hits.size() > k) ? hits[k] : -1, exp0 + k * period);
      end
    end
  endtask

  task automatic test_glitch_free();
    run_write_scenario("glitch_free", 10, 4'd1, 32'hAB00_0005, 1, 42, 24, 5);
  endtask

  task automatic test_collision();
    run_write_scenario("collision", 23, 4'd2, 32'h0000_0003, 2, 36, 24, 3);
  endtask

  task automatic test_bypass_disable();
    exp_t e;
    do_reset();
    for (int n = 0; n < 36; n++) begin
      bus_w = (cyc == 0) || (cyc == 30) || (cyc == 33);
      bus_addr  = (cyc == 0) ? 4'd3 : 4'd4;
      bus_wdata = (cyc == 0) ? 32'd1 : ((cyc == 30) ? 32'h7 : 32'hF);
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL bypass_run cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
      if (cyc == 26 || cyc == 30 || cyc == 34 || cyc == 35) begin
        vectors++;
        if (ce[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL bypass_high cyc=%0d got ce3=%b want 1", cyc, ce[3]);
        end
      end
      if (cyc == 31 || cyc == 33) begin
        vectors++;
        if (ce[3] !== 1'b0 || tick[3] !== 1'b0) begin
          miscompares++;
          $display("FAIL disable_ch3 cyc=%0d got ce3=%b tick3=%b want 0 0", cyc, ce[3], tick[3]);
        end
      end
    end
    bus_w = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int first = 0;
    do_reset();
    repeat (36) begin
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL pre_reset cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({ce, tick, bus_rdata} !== 40'd0) begin
      miscompares++;
      $display("FAIL async_reset got ce=%h tick=%h rdata=%h want all 0", ce, tick, bus_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (30) begin
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL post_reset cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
      if (ce[0] && first == 0) first = cyc;
    end
    vectors++;
    if (first != 24) begin
      miscompares++;
      $display("FAIL post_reset_ce0 got %0d want 24", first);
    end
  endtask

`ifdef CLKGEN_STEP_EN
  task automatic test_step();
    exp_t e;
    int hits[$];
    do_reset();
    bus_addr = 4'd4;
    for (int n = 0; n < 44; n++) begin
      bus_w     = (cyc == 0) || (cyc == 36);
      bus_wdata = (cyc == 0) ? 32'h8000_000F : 32'h0000_000F;
      step_req  = (cyc >= 3 && cyc < 5) || (cyc == 8) || (cyc >= 12 && cyc < 15) ||
                  (cyc >= 19 && cyc < 29);
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL step_run cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
      if (ce[0] && cyc < 36) hits.push_back(cyc);
    end
    bus_w = 1'b0; step_req = 1'b0;
    vectors++;
    if (hits.size() != 4 || hits[0] != 4 || hits[1] != 9 || hits[2] != 13 || hits[3] != 20) begin
      miscompares++;
      $display("FAIL step_pulses got count=%0d want 4 pulses at 4 9 13 20", hits.size());
    end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      bus_w     = ($urandom_range(0, 3) == 0);
      bus_addr  = 4'($urandom_range(0, 6));
      bus_wdata = $urandom;
      if (bus_addr < 4) bus_wdata[23:0] = 24'($urandom_range(0, 6));
      step_req  = ($urandom_range(0, 2) == 0);
      tick_clk();
      e = sb.pop_front();
      vectors++;
      if ({ce, tick, bus_rdata} !== e) begin
        miscompares++;
        $display("FAIL random_bus cyc=%0d got ce=%h tick=%h rdata=%h want ce=%h tick=%h rdata=%h",
                 cyc, ce, tick, bus_rdata, e.ce, e.tick, e.rdata);
      end
    end
    bus_w = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch_free();
    test_collision();
    test_bypass_disable();
    test_reset_mid();
`ifdef CLKGEN_STEP_EN
    test_step();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
